cve2_obi_wb_arbiter: RTL and testbench

Shares one Wishbone master bus (the core_* bus) between the cve2 instruction and data OBI ports when ENABLE_SECOND_MEMORY is off. It converts OBI req/gnt/rvalid into single-outstanding Wishbone classic cycles. Arbitration between the two ports is 2-way round-robin. It sits between cve2_core and the PIPELINED_WISHBONE ack/data registers in processorci_top.

---
 rtl/cve2_obi_wb_pkg.sv | 9 +
 rtl/cve2_rr_arb2.sv | 24 ++
 rtl/cve2_obi_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cve2_obi_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cve2_obi_wb_pkg.sv
// Shared types and constants for the cve2 OBI-to-Wishbone arbiter.
package cve2_obi_wb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  typedef enum logic {OWNER_INSTR, OWNER_DATA} arb_owner_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/cve2_rr_arb2.sv
// Combinational 2-way round-robin arbiter; bit 0 = instruction, bit 1 = data.
module cve2_rr_arb2
  import cve2_obi_wb_pkg::*;
(
  input  logic [1:0] i_req,
  input  arb_owner_e i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_enable) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        // tie goes to whichever port was not served last
        2'b11:   o_gnt = (i_last_grant == OWNER_DATA) ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/cve2_obi_wb_arbiter.sv
// Shares one Wishbone classic master between the cve2 instruction and data OBI
// ports, one transaction in flight. Optional ack watchdog: define ARB_TIMEOUT_EN.
module cve2_obi_wb_arbiter
  import cve2_obi_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  output logic                    instr_err_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i
);

  localparam int SW = DATA_WIDTH / 8;

  arb_state_e              r_state, w_state_nxt;
  arb_owner_e              r_last_grant, r_owner;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [SW-1:0]           r_sel;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_instr_rdata, r_data_rdata;

  logic [1:0]              w_gnt;
  logic                    w_grant, w_busy, w_resp, w_timeout, w_done;
  logic [DATA_WIDTH-1:0]   w_resp_rdata;

  assign w_busy  = (r_state == BUSY);
  assign w_resp  = (r_state == RESP);
  assign w_grant = |w_gnt;
  assign w_done  = w_busy && (wb_ack_i || w_timeout);
  // ack wins over a coinciding timeout
  assign w_resp_rdata = wb_ack_i ? wb_data_i : DATA_WIDTH'(TIMEOUT_RDATA);

  // gated by rst_ni so no grant leaks out while reset is held
  cve2_rr_arb2 u_rr_arb2 (
    .i_req        ({data_req_i, instr_req_i}),
    .i_last_grant (r_last_grant),
    .i_enable     ((r_state == IDLE) && rst_ni),
    .o_gnt        (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_state_nxt = BUSY;
      BUSY:    if (wb_ack_i || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_last_grant  <= OWNER_DATA;
      r_owner       <= OWNER_INSTR;
      r_addr        <= '0;
      r_we          <= 1'b0;
      r_sel         <= '0;
      r_wdata       <= '0;
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner      <= w_gnt[1] ? OWNER_DATA : OWNER_INSTR;
        r_last_grant <= w_gnt[1] ? OWNER_DATA : OWNER_INSTR;
        r_addr       <= w_gnt[1] ? data_addr_i : instr_addr_i;
        r_we         <= w_gnt[1] & data_we_i;
        r_sel        <= w_gnt[1] ? data_be_i : '1;
        r_wdata      <= w_gnt[1] ? data_wdata_i : '0;
      end
      if (w_done) begin
        if (r_owner == OWNER_DATA) r_data_rdata  <= w_resp_rdata;
        else                       r_instr_rdata <= w_resp_rdata;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_tmo_cnt;
  logic          r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_grant)                 r_tmo_cnt <= '0;
      else if (w_busy && !wb_ack_i) r_tmo_cnt <= r_tmo_cnt + CW'(1);
      if (w_done)                  r_err     <= !wb_ack_i;
    end
  end

  assign w_timeout   = w_busy && !wb_ack_i && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign instr_err_o = w_resp && (r_owner == OWNER_INSTR) && r_err;
  assign data_err_o  = w_resp && (r_owner == OWNER_DATA) && r_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
  assign instr_err_o  = 1'b0;
  assign data_err_o   = 1'b0;
`endif

  assign instr_gnt_o    = w_gnt[0];
  assign data_gnt_o     = w_gnt[1];
  assign instr_rvalid_o = w_resp && (r_owner == OWNER_INSTR);
  assign data_rvalid_o  = w_resp && (r_owner == OWNER_DATA);
  assign instr_rdata_o  = r_instr_rdata;
  assign data_rdata_o   = r_data_rdata;

  assign wb_cyc_o  = w_busy;
  assign wb_stb_o  = w_busy;
  assign wb_we_o   = w_busy & r_we;
  assign wb_sel_o  = w_busy ? r_sel : '0;
  assign wb_addr_o = w_busy ? r_addr : '0;
  assign wb_data_o = w_busy ? r_wdata : '0;

endmodule

// File: tb/tb_cve2_obi_wb_arbiter.sv
// Scoreboard bench for cve2_obi_wb_arbiter with a Wishbone slave model.
module tb_cve2_obi_wb_arbiter;
  localparam int TMO = 8;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        instr_req_i = 0, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i = '0, instr_rdata_o;
  logic        data_req_i = 0, data_gnt_o, data_rvalid_o, data_we_i = 0, data_err_o;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0, data_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 0;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i = '0;

  cve2_obi_wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        own;   // 0 instr, 1 data
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t busq[$], respq[$];
  logic gexp[$];
  txn_t t, tr;
  int vec_cnt = 0, err_cnt = 0, cyc_n = 0;
  int ack_delay = 1, busy_len = 0, last_busy = 0, last_ack_cyc = -10, last_rv_cyc = -10;
  int ngnt = 0;
  bit slave_en = 1, stray_ack = 0, exp_tmo = 0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : ({a[15:0], a[31:16]} ^ 32'hA5A5_0F0F);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask

  always @(posedge clk_i) cyc_n++;

  // monitor + scoreboard + slave model, all on the inactive edge
  always @(negedge clk_i) begin
    if (!wb_cyc_o) begin
      if (busy_len != 0) last_busy = busy_len;
      busy_len = 0;
    end else busy_len++;
    if (rst_ni) begin
      if (instr_rvalid_o || data_rvalid_o) begin
        last_rv_cyc = cyc_n;
        if (busq.size() != 0) void'(busq.pop_front());
        if (respq.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
        else begin
          tr = respq.pop_front();
          chk("rv_owner", 32'({instr_rvalid_o, data_rvalid_o}), tr.own ? 32'd1 : 32'd2);
          chk("rv_cyc_low", 32'(wb_cyc_o), 32'd0);
          if (!tr.we || tr.err) chk("rdata", tr.own ? data_rdata_o : instr_rdata_o, tr.rdata);
          chk("err", 32'(tr.own ? data_err_o : instr_err_o), 32'(tr.err));
          chk("err_other", 32'(tr.own ? instr_err_o : data_err_o), 32'd0);
          if (tr.err) chk("tmo_busy_len", 32'(last_busy), 32'(TMO));
          else        chk("rv_latency", 32'(cyc_n - last_ack_cyc), 32'd1);
        end
      end
      if (instr_gnt_o || data_gnt_o) begin
        ngnt++;
        chk("gnt_onehot", 32'(instr_gnt_o & data_gnt_o), 32'd0);
        chk("gnt_has_req", 32'(instr_gnt_o ? instr_req_i : data_req_i), 32'd1);
        chk("gnt_after_resp", 32'(cyc_n > last_rv_cyc), 32'd1);
        t.own   = data_gnt_o;
        t.addr  = data_gnt_o ? data_addr_i : instr_addr_i;
        t.we    = data_gnt_o & data_we_i;
        t.sel   = data_gnt_o ? data_be_i : 4'hF;
        t.wdata = data_wdata_i;
        t.rdata = exp_tmo ? 32'hDEADBEEF : rd_model(t.addr);
        t.err   = exp_tmo;
        if (gexp.size() != 0) chk("gnt_order", 32'(t.own), 32'(gexp.pop_front()));
        busq.push_back(t);
        respq.push_back(t);
      end
      if (wb_cyc_o) begin
        if (busq.size() == 0) chk("cyc_unexpected", 32'd1, 32'd0);
        else begin
          chk("stb", 32'(wb_stb_o), 32'd1);
          chk("addr", wb_addr_o, busq[0].addr);
          chk("we", 32'(wb_we_o), 32'(busq[0].we));
          chk("sel", 32'(wb_sel_o), 32'(busq[0].sel));
          if (busq[0].we) chk("wdata", wb_data_o, busq[0].wdata);
        end
      end
    end
    wb_ack_i = 1'b0;
    if (wb_cyc_o && slave_en && busy_len == ack_delay) begin
      wb_ack_i     = 1'b1;
      wb_data_i    = rd_model(wb_addr_o);
      last_ack_cyc = cyc_n;
      if (busq.size() != 0) void'(busq.pop_front());
    end else if (stray_ack) begin
      wb_ack_i  = 1'b1;
      wb_data_i = 32'hBAD0_BAD0;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk_i); #1; n++; end
    while ((respq.size() != 0 || wb_cyc_o) && n < 300);
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic obi(input bit port, input logic [31:0] a, input logic we,
                     input logic [3:0] be, input logic [31:0] wd, output int lat);
    int n = 0;
    @(posedge clk_i); #1;
    if (!port) begin instr_req_i = 1; instr_addr_i = a; end
    else begin
      data_req_i = 1; data_addr_i = a; data_we_i = we; data_be_i = be; data_wdata_i = wd;
    end
    do begin @(negedge clk_i); n++; end
    while (!(port ? data_gnt_o : instr_gnt_o) && n < 100);
    chk("gnt_wait", 32'(n < 100), 32'd1);
    lat = n;
    @(posedge clk_i); #1;
    instr_req_i = 0; data_req_i = 0;
    // scramble inputs: the bus must use the latched copy
    instr_addr_i = 32'hFFFF_FFF0; data_addr_i = 32'hFFFF_FFF0; data_wdata_i = 32'h0; data_be_i = 4'h0;
    wait_idle("rsp_wait");
  endtask

  task automatic do_reset();
    rst_ni = 0; instr_req_i = 0; data_req_i = 0; stray_ack = 0; slave_en = 1; exp_tmo = 0;
    busq.delete(); respq.delete(); gexp.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
  endtask

  int lat, base, n;

  initial begin
    do_reset();
    // reset state
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_rdata", instr_rdata_o | data_rdata_o, 32'd0);
    chk("rst_rvalid", 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);

    // 1: instruction fetch, ack 3 cycles after cyc
    ack_delay = 3;
    obi(0, 32'h100, 0, 4'h0, 32'h0, lat);
    chk("t1_gnt_same_cycle", 32'(lat), 32'd1);
    chk("t1_rdata_hold", instr_rdata_o, 32'h13);

    // 2: data write, immediate ack
    ack_delay = 1;
    obi(1, 32'h2000, 1, 4'h3, 32'hCAFEBABE, lat);
    chk("t2_gnt_same_cycle", 32'(lat), 32'd1);
    chk("t2_instr_rdata_held", instr_rdata_o, 32'h13);

    // data read with longer latency
    ack_delay = 4;
    obi(1, 32'h0000_2468, 0, 4'hF, 32'h0, lat);
    chk("rd_hold", data_rdata_o, rd_model(32'h0000_2468));

    // 3: both ports requesting continuously, round-robin from reset
    do_reset();
    ack_delay = 2;
    gexp.push_back(0); gexp.push_back(1); gexp.push_back(0); gexp.push_back(1);
    @(posedge clk_i); #1;
    instr_addr_i = 32'h300; data_addr_i = 32'h400; data_we_i = 0; data_be_i = 4'hF;
    instr_req_i = 1; data_req_i = 1;
    base = ngnt; n = 0;
    while (ngnt - base < 4 && n < 300) begin @(negedge clk_i); #1; n++; end
    chk("t3_rr_grants", 32'(ngnt - base), 32'd4);
    @(posedge clk_i); #1;
    instr_req_i = 0; data_req_i = 0;
    wait_idle("t3_drain");
    chk("t3_order_consumed", 32'(gexp.size()), 32'd0);

    // 4: async reset while BUSY
    ack_delay = 6;
    @(posedge clk_i); #1;
    instr_req_i = 1; instr_addr_i = 32'h500;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!instr_gnt_o && n < 50);
    @(posedge clk_i); #1; instr_req_i = 0;
    @(posedge clk_i); #2;
    chk("t4_busy", 32'(wb_cyc_o), 32'd1);
    rst_ni = 0;
    #1;
    chk("t4_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
    chk("t4_gnt_rvalid", 32'({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}), 32'd0);
    chk("t4_bus_fields", wb_addr_o | 32'(wb_sel_o), 32'd0);
    chk("t4_rdata", instr_rdata_o | data_rdata_o, 32'd0);
    busq.delete(); respq.delete();
    @(posedge clk_i); #1 rst_ni = 1;
    ack_delay = 1;
    obi(0, 32'h600, 0, 4'h0, 32'h0, lat);
    chk("t4_regrant", 32'(lat), 32'd1);

    // 6: spurious ack in IDLE
    @(posedge clk_i); #1; stray_ack = 1;
    repeat (4) begin
      @(negedge clk_i); #1;
      chk("t6_idle_quiet", 32'({wb_cyc_o, instr_rvalid_o, data_rvalid_o}), 32'd0);
    end
    stray_ack = 0;
    @(negedge clk_i); #1;
    chk("t6_rdata_kept", instr_rdata_o, rd_model(32'h600));
    obi(1, 32'h0000_7000, 0, 4'hF, 32'h0, lat);
    chk("t6_after_stray", data_rdata_o, rd_model(32'h0000_7000));

`ifdef ARB_TIMEOUT_EN
    // 5: watchdog expiry, then a late ack
    exp_tmo = 1; slave_en = 0;
    obi(1, 32'h3000, 0, 4'hF, 32'h0, lat);
    chk("t5_rdata_tmo", data_rdata_o, 32'hDEADBEEF);
    exp_tmo = 0; stray_ack = 1;
    repeat (3) @(negedge clk_i);
    #1 stray_ack = 0; slave_en = 1;
    obi(0, 32'h100, 0, 4'h0, 32'h0, lat);
`else
    // no watchdog: a long-latency slave is simply waited for
    ack_delay = 40;
    obi(0, 32'h0000_0A00, 0, 4'h0, 32'h0, lat);
    chk("long_wait_rdata", instr_rdata_o, rd_model(32'h0000_0A00));
`endif

    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, vectors %0d", vec_cnt);
    $fatal(1);
  end

endmodule
